// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
// Shared types and default timing constants for the front-panel button
// conditioner (panel_btn_cond and its per-channel block btn_debounce_ch).
//
// Optional feature macro: PANEL_BTN_REPEAT_EN (auto-repeat FSMs). The repeat
// state type below is only referenced when that macro is defined.
// -----------------------------------------------------------------------------
package panel_pkg;

    // Auto-repeat sequencer states.
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    // Default timing at a 25 MHz panel clock.
    localparam int DEB_10MS_25M  = 250_000;     // 10 ms debounce window
    localparam int REP_500MS_25M = 12_500_000;  // 500 ms hold before first repeat
    localparam int REP_100MS_25M = 2_500_000;   // 100 ms between repeats

endpackage

// File: rtl/panel_btn_cond_if.sv
// -----------------------------------------------------------------------------
// panel_btn_cond_if
// Bundle of the button conditioner's data signals.
//   btn_i      raw asynchronous button levels          (master -> slave)
//   irq_ack_i  one-cycle pulse clearing changed_o      (master -> slave)
//   stable_o   debounced active-high levels            (slave -> master)
//   press_o    press / auto-repeat pulses              (slave -> master)
//   release_o  release pulses                          (slave -> master)
//   changed_o  sticky changed-channel mask             (slave -> master)
//   irq_o      high while changed_o is nonzero         (slave -> master)
// The conditioner uses the slave modport; whoever drives the raw buttons and
// services the IRQ uses the master modport.
// Optional feature macro: PANEL_BTN_REPEAT_EN (no effect on this file).
// -----------------------------------------------------------------------------
interface panel_btn_cond_if #(
    parameter int N_BTN = 7
);
    logic [N_BTN-1:0] btn_i;
    logic             irq_ack_i;
    logic [N_BTN-1:0] stable_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] changed_o;
    logic             irq_o;

    modport master (
        output btn_i, irq_ack_i,
        input  stable_o, press_o, release_o, changed_o, irq_o
    );

    modport slave (
        input  btn_i, irq_ack_i,
        output stable_o, press_o, release_o, changed_o, irq_o
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchroniser, optional inversion, debounce
// counter, registered press/release pulses and (optionally) auto-repeat.
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   btn_i      raw asynchronous button level
//   stable_o   debounced active-high level
//   press_o    one-cycle pulse on debounced press and on each auto-repeat
//   release_o  one-cycle pulse on debounced release
//   edge_o     combinational: stable level changed on the previous edge
// Optional feature macro: PANEL_BTN_REPEAT_EN adds the repeat FSM and the
// REP_DELAY_CYC / REP_RATE_CYC / REP_EN parameters; without it press_o is
// edge-only.
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import panel_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_10MS_25M,
`ifdef PANEL_BTN_REPEAT_EN
    parameter int REP_DELAY_CYC = REP_500MS_25M,
    parameter int REP_RATE_CYC  = REP_100MS_25M,
    parameter bit REP_EN        = 1'b0,
`endif
    parameter bit INV           = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o,
    output logic edge_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          raw_s;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, release_q;
    logic          rise_evt, fall_evt;
    logic          rep_pulse;

    assign raw_s = sync2_q ^ INV;

    // Count consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (raw_s != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // stable_dly_q lags stable_q by one cycle so the pulses land the cycle
    // after the debounced level moves.
    assign rise_evt = stable_q & ~stable_dly_q;
    assign fall_evt = ~stable_q & stable_dly_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= rise_evt | rep_pulse;
            release_q    <= fall_evt;
        end
    end

`ifdef PANEL_BTN_REPEAT_EN
    localparam int TMAX = (REP_DELAY_CYC > REP_RATE_CYC) ? REP_DELAY_CYC : REP_RATE_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    rep_state_t    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;

    // The FSM arms on the same rise event that produces the press pulse, so
    // the first repeat is always REP_DELAY_CYC cycles after that pulse.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        rep_pulse = 1'b0;
        if (!REP_EN || !stable_q) begin
            state_d = REP_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                REP_IDLE: begin
                    if (rise_evt) begin
                        state_d = REP_DELAY;
                        tmr_d   = TW'(REP_DELAY_CYC - 1);
                    end
                end
                REP_DELAY, REP_REPEAT: begin
                    if (tmr_q == '0) begin
                        rep_pulse = 1'b1;
                        state_d   = REP_REPEAT;
                        tmr_d     = TW'(REP_RATE_CYC - 1);
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                default: state_d = REP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= REP_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign edge_o    = stable_q ^ stable_dly_q;

endmodule

// File: rtl/panel_btn_cond.sv
// -----------------------------------------------------------------------------
// panel_btn_cond
// Front-panel button conditioner: N_BTN independent debounce channels plus a
// sticky change mask and IRQ for the SPI slave.
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous active-low reset
//   bus     panel_btn_cond_if.slave: btn_i, irq_ack_i in; stable_o, press_o,
//           release_o, changed_o, irq_o out
// Optional feature macro: PANEL_BTN_REPEAT_EN enables auto-repeat and the
// REP_DELAY / REP_RATE / REP_MASK parameters.
// -----------------------------------------------------------------------------
module panel_btn_cond
    import panel_pkg::*;
#(
    parameter int               N_BTN      = 7,
    parameter int               DEB_CYCLES = DEB_10MS_25M,
`ifdef PANEL_BTN_REPEAT_EN
    parameter int               REP_DELAY  = REP_500MS_25M,
    parameter int               REP_RATE   = REP_100MS_25M,
    parameter logic [N_BTN-1:0] REP_MASK   = N_BTN'(7'b0101000),
`endif
    parameter logic [N_BTN-1:0] INV_MASK   = N_BTN'(7'b0000001)
) (
    input logic             clk,
    input logic             resetn,
    panel_btn_cond_if.slave bus
);

    logic [N_BTN-1:0] stable_w, press_w, release_w, edge_w;
    logic [N_BTN-1:0] changed_q, changed_d;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
`ifdef PANEL_BTN_REPEAT_EN
            .REP_DELAY_CYC (REP_DELAY),
            .REP_RATE_CYC  (REP_RATE),
            .REP_EN        (REP_MASK[gi]),
`endif
            .INV           (INV_MASK[gi])
        ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .btn_i     (bus.btn_i[gi]),
            .stable_o  (stable_w[gi]),
            .press_o   (press_w[gi]),
            .release_o (release_w[gi]),
            .edge_o    (edge_w[gi])
        );
    end

    // Ack clears everything, but an edge arriving in the same cycle survives.
    always_comb begin
        changed_d = (changed_q & {N_BTN{~bus.irq_ack_i}}) | edge_w;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.stable_o  = stable_w;
    assign bus.press_o   = press_w;
    assign bus.release_o = release_w;
    assign bus.changed_o = changed_q;
    assign bus.irq_o     = |changed_q;

endmodule
